// File: rtl/lsr_shift_sequencer_if.sv
// lsr_shift_sequencer_if: operand/result handshake bundle for the multi-cycle shifter
interface lsr_shift_sequencer_if #(
  parameter int WIDTH = 64,
  parameter int SHW = $clog2(WIDTH)
);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0] in_shamt;
  logic flush;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] out_data;
  logic busy;
  modport master (
    output in_valid, in_data, in_shamt, flush, out_ready,
    input in_ready, out_valid, out_data, busy
  );
  modport slave (
    input in_valid, in_data, in_shamt, flush, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/lsr_shift_sequencer.sv
// lsr_shift_sequencer: logical shift right resolved one power-of-two stage per cycle, MSB stage first
module lsr_shift_sequencer #(
  parameter int WIDTH = 64
) (
  input logic clk,
  input logic rst_n,
  lsr_shift_sequencer_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int SW = (SHW > 1) ? $clog2(SHW) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, acc_sh, out_q, out_d;
  logic [SHW-1:0] amt_q, amt_d, en;
  logic [SW-1:0] stage_q, stage_d;
  for (genvar k = 0; k < SHW; k++) begin : g_unit
    assign en[k] = (state_q == SHIFT) && (stage_q == SW'(k)) && amt_q[k];
  end
  always_comb begin
    acc_sh = acc_q;
    for (int k = 0; k < SHW; k++) if (en[k]) acc_sh = acc_q >> (1 << k);
  end
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    amt_d = amt_q;
    stage_d = stage_q;
    out_d = out_q;
    if (state_q == IDLE && bus.in_valid && !bus.flush) begin
      state_d = SHIFT;
      acc_d = bus.in_data;
      amt_d = bus.in_shamt;
      stage_d = SW'(SHW - 1);
    end
    if (state_q == SHIFT) begin
      acc_d = acc_sh;
      stage_d = (stage_q == '0) ? stage_q : stage_q - SW'(1);
      if (stage_q == '0) state_d = DONE;
      // result register only moves on a real entry into DONE, so a flushed op leaves it untouched
      if (stage_q == '0 && !bus.flush) out_d = acc_sh;
    end
    if (state_q == DONE && bus.out_ready) state_d = IDLE;
    if (bus.flush) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q <= '0;
      amt_q <= '0;
      stage_q <= '0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      amt_q <= amt_d;
      stage_q <= stage_d;
      out_q <= out_d;
    end
  end
  assign bus.in_ready = (state_q == IDLE) && !bus.flush;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy = (state_q != IDLE);
  assign bus.out_data = out_q;
endmodule

// File: doc/lsr_shift_sequencer.md
# lsr_shift_sequencer

Multi-cycle logical-shift-right engine for the execute stage. It accepts a WIDTH-bit operand and a shift amount over a valid/ready handshake. It resolves the shift one power-of-two stage per cycle, MSB stage first, by enabling fixed-shift units (shift by 2^k, zero-fill). It then holds the result until the consumer accepts it, trading latency for area versus a full single-cycle barrel shifter.

## Interface
- WIDTH, 64, operand/result width; power of two, ≥2
- SHW, $clog2(WIDTH) = 6, shift-amount width and number of shift stages
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand and shift amount presented
- in_ready  output  1  block can accept; high only in IDLE with flush low
- in_data  input  WIDTH  operand to shift
- in_shamt  input  SHW  unsigned shift amount, 0..WIDTH-1
- flush  input  1  pipeline flush; aborts any operation in progress
- out_valid  output  1  result valid; high only in DONE
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  shifted result; registered
- busy  output  1  high in SHIFT or DONE

## Operation
- States: IDLE, SHIFT, DONE. Internal regs: acc[WIDTH], amt[SHW], stage[$clog2(SHW)].
- IDLE: in_ready = !flush. On in_valid && in_ready, latch acc←in_data, amt←in_shamt, stage←SHW-1, and go to SHIFT. No transfer leaves all regs unchanged.
- SHIFT: each cycle, acc ← amt[stage] ? (acc >> 2^stage, zero-filled) : acc.
  - One fixed-shift unit exists per k in 0..SHW-1. Unit k is enabled only when state==SHIFT && stage==k && amt[k].
  - At most one unit is enabled per cycle. A disabled unit passes acc through unchanged.
  - If stage==0, go to DONE; else stage decrements.
- DONE: out_valid=1, out_data=acc. On out_ready, go to IDLE. A new operand is never accepted in the same cycle the result is taken.
- Result equals in_data >> in_shamt (logical, zero-fill), bit-exact for every shamt 0..WIDTH-1.
- shamt=0 still takes the full SHW shift cycles; no early exit.
- flush (any state) forces IDLE on the next edge. Flush priority:
  - over out_ready: a result in DONE is dropped and never handshaken
  - over in_valid: in_ready is low while flush is high
- in_data and in_shamt are sampled only at the accept edge. Later changes have no effect on the operation in flight.
- out_data is stable while out_valid is high and out_ready is low. It keeps its last value outside DONE.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, acc=0, amt=0, stage=0, out_valid=0, busy=0, out_data=0, in_ready=1 (combinational, flush low).
- Reset deassertion mid-operation resumes in IDLE. The aborted operation produces no out_valid.
- Latency: accept at edge N. SHIFT spans the cycles after edges N..N+SHW-1. out_valid rises after edge N+SHW (6 for default).
- Minimum initiation interval: SHW+2 cycles (accept, SHW shift cycles, DONE with out_ready high), i.e. 8 for default.
- Outputs in_ready, out_valid, and busy decode state directly. in_ready additionally gates on flush. There are no other combinational paths from inputs to outputs.
- Backpressure: DONE persists indefinitely while out_ready is low.

## Test plan
- Basic: in_data=0x0000_0000_0000_0004, shamt=2 → out_data=0x1, out_valid exactly 6 cycles after the accept edge, busy high for those cycles.
- Extremes: 0xFFFF_FFFF_FFFF_FFFF with shamt=63 → 0x1. 0x8000_0000_0000_0000 with shamt=0 → unchanged. Check a 1000-vector random sweep against a >> reference model.
- Backpressure and input stability: hold out_ready low 10 cycles in DONE → out_data is constant and in_ready stays low. Changing in_data/in_shamt during SHIFT does not alter the result. After the out_ready pulse, in_ready is high on the next cycle only.
- Flush: assert flush in the 3rd SHIFT cycle → IDLE next edge, no out_valid. Flush asserted with out_ready in DONE → result dropped. Flush concurrent with in_valid in IDLE → no accept.
- Reset: drop rst_n mid-SHIFT, asynchronously between edges → all outputs take reset values immediately. After release, shamt=5 on 0x20 → 0x1.
- Back-to-back: two ops with out_ready tied high → accept edges 8 cycles apart, both results correct.
